uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, meaning number of byte sources sharing one UART transmitter (legal 2..8).
REQ-002 SHALL have parameter START_TIMEOUT, default 32'd64, meaning max CLK_i cycles to wait for transmitter rts to fall after tx_valid_o rises.
REQ-003 SHALL have port CLK_i  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-high reset (despite the name).
REQ-005 SHALL have port req_i  input  NUM_SRC  per-source request; bit i high = source i holds a byte.
REQ-006 SHALL have port data_i  input  8*NUM_SRC  byte of source i on bits [8i+7:8i].
REQ-007 SHALL have port grant_o  output  NUM_SRC  one-hot, one-cycle pulse: source i's byte is latched.
REQ-008 SHALL have port tx_valid_o  output  1  drives transmitter dataReady.
REQ-009 SHALL have port tx_data_o  output  8  drives transmitter data; held stable for the whole frame.
REQ-010 SHALL have port tx_rts_i  input  1  transmitter rts (1 = idle/ready, 0 = frame in progress).
REQ-011 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-012 SHALL have port frame_cnt_o  output  16  count of completed frames, wraps 0xFFFF->0x0000.
REQ-013 SHALL have port err_timeout_o  output  1  sticky flag: a start timeout occurred.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT_START, WAIT_DONE.
REQ-015 IDLE: when req_i != 0 and tx_rts_i == 1, SHALL select winner by round-robin, latch its byte into tx_data_o, pulse grant_o[winner] in the same cycle, go to LOAD.
REQ-016 IDLE with req_i == 0 or tx_rts_i == 0 SHALL remain in IDLE with grant_o == 0.
REQ-017 Round-robin: search starts at index ptr, ascending, wrapping NUM_SRC-1 -> 0; after a grant to i, ptr SHALL become (i+1) mod NUM_SRC.
REQ-018 LOAD: SHALL assert tx_valid_o, clear timeout counter, go to WAIT_START next cycle.
REQ-019 WAIT_START: tx_valid_o stays high; on tx_rts_i == 0 SHALL deassert tx_valid_o and go to WAIT_DONE.
REQ-020 WAIT_START: if START_TIMEOUT cycles elapse with tx_rts_i still 1, SHALL deassert tx_valid_o, set err_timeout_o, go to IDLE; byte is dropped and frame_cnt_o unchanged.
REQ-021 WAIT_DONE: on tx_rts_i == 1 SHALL increment frame_cnt_o by 1 (mod 2^16) and go to IDLE.
REQ-022 tx_data_o SHALL change only on a grant; it holds from grant until the next grant, including through WAIT_DONE.
REQ-023 Sources MAY drop req_i or change data_i the cycle after their grant pulse; the arbiter SHALL NOT re-sample data_i before the next grant.
REQ-024 A request deasserted before being granted SHALL be ignored (no grant, no frame).
REQ-025 Back-to-back: at most one frame in flight; next grant no earlier than the cycle after returning to IDLE.
REQ-026 Simultaneous tx_rts_i rise in WAIT_DONE and new req_i SHALL first go to IDLE, with the grant evaluated in the following cycle.
REQ-027 err_timeout_o SHALL stay set until reset; it SHALL NOT block further arbitration.

Reset
REQ-028 reset_n high SHALL immediately force: state IDLE, ptr 0, grant_o 0, tx_valid_o 0, tx_data_o 8'h00, busy_o 0, frame_cnt_o 0, err_timeout_o 0, timeout counter 0.
REQ-029 Reset mid-frame SHALL abandon the frame without a grant or count; after release, the arbiter SHALL wait in IDLE for tx_rts_i == 1 before granting.

Verification
REQ-030 Single source: req_i=4'b0100, data_i byte2=8'hA5 -> grant_o=4'b0100 for 1 cycle, tx_data_o=8'hA5, tx_valid_o high until rts falls, frame_cnt_o=1 after rts rises.
REQ-031 Fairness: req_i=4'b1111 held, transmitter model with rts low for 10 cycles per frame -> grants in order 0,1,2,3,0; frame_cnt_o=5.
REQ-032 Wrap of pointer: last grant 3, req_i=4'b1001 -> next grant source 0, then source 3.
REQ-033 Timeout: tx_rts_i stuck at 1 -> tx_valid_o drops after 64 cycles in WAIT_START, err_timeout_o=1, frame_cnt_o unchanged, next request still granted.
REQ-034 Reset mid-frame: assert reset_n during WAIT_DONE -> all outputs at REQ-028 values within the same cycle; no grant until tx_rts_i=1 after release.
REQ-035 Counter wrap: preload by 65535 frames (or force) -> next completed frame gives frame_cnt_o=16'h0000.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_SRC byte sources. Sources are served
// round-robin, one frame at a time. The chosen byte is latched on the grant and
// held on tx_data_o until the next grant, so sources may change their data
// freely once they have seen their grant pulse.
//
// Parameters
//   NUM_SRC        number of byte sources (2..8)
//   START_TIMEOUT  cycles to wait in WAIT_START for the transmitter's rts
//                  to fall before the byte is dropped
//
// Ports
//   CLK_i          system clock, rising edge
//   reset_n        asynchronous reset, ACTIVE HIGH despite its name
//   req_i          per-source request, bit i = source i holds a byte
//   data_i         byte of source i on bits [8i+7:8i]
//   grant_o        one-hot, one-cycle pulse: source's byte has been latched
//   tx_valid_o     transmitter dataReady
//   tx_data_o      transmitter data, stable for the whole frame
//   tx_rts_i       transmitter rts (1 = idle/ready, 0 = frame in progress)
//   busy_o         high whenever the FSM is not in IDLE
//   frame_cnt_o    completed frame count, wraps at 16 bits
//   err_timeout_o  sticky start-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int          NUM_SRC       = 4,
    parameter logic [31:0] START_TIMEOUT = 32'd64
) (
    input  logic                   CLK_i,
    input  logic                   reset_n,
    input  logic [NUM_SRC-1:0]     req_i,
    input  logic [8*NUM_SRC-1:0]   data_i,
    output logic [NUM_SRC-1:0]     grant_o,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    input  logic                   tx_rts_i,
    output logic                   busy_o,
    output logic [15:0]            frame_cnt_o,
    output logic                   err_timeout_o
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_START,
        WAIT_DONE
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     winner;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     ptr_next;
    logic                 found;
    logic [7:0]           sel_byte;
    logic                 do_grant;
    logic                 timeout_hit;

    logic [NUM_SRC-1:0]   grant_q;
    logic [7:0]           tx_data_q;
    logic [15:0]          frame_cnt_q;
    logic                 err_q;
    logic [31:0]          to_cnt_q;

    // Round-robin search: first requesting source at or above ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = PTR_W'((int'(ptr_q) + k) % NUM_SRC);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Byte of the winning source and the pointer value that follows it.
    always_comb begin
        sel_byte = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (winner == PTR_W'(i)) begin
                sel_byte = data_i[8*i +: 8];
            end
        end
        ptr_next = (winner == PTR_W'(NUM_SRC - 1)) ? '0 : winner + PTR_W'(1);
    end

    // A grant only happens from IDLE, so a frame finishing in WAIT_DONE always
    // spends one IDLE cycle before the next source is chosen.
    assign do_grant    = (state_q == IDLE) && found && tx_rts_i;
    assign timeout_hit = (to_cnt_q >= (START_TIMEOUT - 32'd1));

    // State register.
    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (do_grant) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = WAIT_START;
            end
            WAIT_START: begin
                if (!tx_rts_i) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (tx_rts_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        tx_valid_o = 1'b0;
        busy_o     = 1'b0;
        case (state_q)
            IDLE:       begin tx_valid_o = 1'b0; busy_o = 1'b0; end
            LOAD:       begin tx_valid_o = 1'b1; busy_o = 1'b1; end
            WAIT_START: begin tx_valid_o = 1'b1; busy_o = 1'b1; end
            WAIT_DONE:  begin tx_valid_o = 1'b0; busy_o = 1'b1; end
            default:    begin tx_valid_o = 1'b0; busy_o = 1'b0; end
        endcase
    end

    // Datapath: the grant pulse is registered so it appears in LOAD together
    // with the freshly latched byte; the timeout counter only advances while
    // the transmitter has not yet started.
    always_ff @(posedge CLK_i or posedge reset_n) begin
        if (reset_n) begin
            ptr_q       <= '0;
            grant_q     <= '0;
            tx_data_q   <= 8'h00;
            frame_cnt_q <= 16'h0000;
            err_q       <= 1'b0;
            to_cnt_q    <= 32'd0;
        end else begin
            grant_q <= '0;
            if (do_grant) begin
                grant_q   <= NUM_SRC'(1) << winner;
                tx_data_q <= sel_byte;
                ptr_q     <= ptr_next;
            end

            if (state_q == LOAD) begin
                to_cnt_q <= 32'd0;
            end else if ((state_q == WAIT_START) && tx_rts_i && !timeout_hit) begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end

            if ((state_q == WAIT_START) && tx_rts_i && timeout_hit) begin
                err_q <= 1'b1;
            end

            if ((state_q == WAIT_DONE) && tx_rts_i) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign grant_o       = grant_q;
    assign tx_data_o     = tx_data_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign err_timeout_o = err_q;

endmodule
